// File: rtl/perm_noc_pkg.sv
// Shared types, command codes and helpers for the permutation NoC controller.
package perm_noc_pkg;

    localparam int         NWORDS_DEF = 25;
    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_START  = 8'h01;

    typedef enum logic [1:0] {
        IN_IDLE  = 2'd0,
        IN_LOAD  = 2'd1,
        IN_FLUSH = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_HDR  = 2'd1,
        O_DATA = 2'd2
    } out_state_t;

    // Drop byte b into lane idx of the 7-byte assembly register; lane 7 is
    // never stored because the 8th byte goes straight into the word register.
    function automatic logic [55:0] asm_put(input logic [55:0] a,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  b);
        logic [55:0] r;
        r = a;
        case (idx)
            3'd0:    r[7:0]   = b;
            3'd1:    r[15:8]  = b;
            3'd2:    r[23:16] = b;
            3'd3:    r[31:24] = b;
            3'd4:    r[39:32] = b;
            3'd5:    r[47:40] = b;
            3'd6:    r[55:48] = b;
            default: r        = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/perm_noc_ctl_if.sv
// NoC byte links and perm-engine word handshake of the controller.
interface perm_noc_ctl_if;

    logic        noc_to_dev_ctl;
    logic [7:0]  noc_to_dev_data;
    logic        noc_from_dev_ctl;
    logic [7:0]  noc_from_dev_data;
    logic        pushin;
    logic        firstin;
    logic        stopin;
    logic [63:0] din;
    logic        pushout;
    logic        firstout;
    logic        stopout;
    logic [63:0] dout;

    // Controller side.
    modport master (
        input  noc_to_dev_ctl, noc_to_dev_data, stopin, pushout, firstout, dout,
        output noc_from_dev_ctl, noc_from_dev_data, pushin, firstin, din, stopout
    );

    // NoC / perm-engine side.
    modport slave (
        output noc_to_dev_ctl, noc_to_dev_data, stopin, pushout, firstout, dout,
        input  noc_from_dev_ctl, noc_from_dev_data, pushin, firstin, din, stopout
    );

endinterface

// File: rtl/perm_noc_ser.sv
// Result-word serializer: captures one 64-bit word and emits an optional
// header byte followed by eight data bytes, LSB first.
module perm_noc_ser
    import perm_noc_pkg::*;
#(
    parameter logic [7:0] HDR_OUT = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pushout,
    input  logic        i_firstout,
    input  logic [63:0] i_dout,
    output logic        o_stopout,
    output logic        o_ctl,
    output logic [7:0]  o_data
);

    out_state_t  r_state;
    logic [63:0] r_sh;
    logic [2:0]  r_bcnt;
    logic        r_stopout;
    logic        r_ctl;
    logic [7:0]  r_data;
    logic        w_cap;

    // A word is taken only while stopout is low (idle or last byte cycle).
    always_comb begin
        w_cap = i_pushout && !r_stopout;
    end

    // Serializer FSM; outputs and stopout are loaded one cycle ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= O_IDLE;
            r_sh      <= 64'd0;
            r_bcnt    <= 3'd0;
            r_stopout <= 1'b0;
            r_ctl     <= 1'b1;
            r_data    <= 8'h00;
        end else if (w_cap) begin
            r_stopout <= 1'b1;
            r_bcnt    <= 3'd0;
            if (i_firstout) begin
                r_state <= O_HDR;
                r_ctl   <= 1'b1;
                r_data  <= HDR_OUT;
                r_sh    <= i_dout;
            end else begin
                r_state <= O_DATA;
                r_ctl   <= 1'b0;
                r_data  <= i_dout[7:0];
                r_sh    <= {8'h00, i_dout[63:8]};
            end
        end else begin
            case (r_state)
                O_IDLE: begin
                    r_ctl     <= 1'b1;
                    r_data    <= 8'h00;
                    r_stopout <= 1'b0;
                end
                O_HDR: begin
                    r_state   <= O_DATA;
                    r_ctl     <= 1'b0;
                    r_data    <= r_sh[7:0];
                    r_sh      <= {8'h00, r_sh[63:8]};
                    r_bcnt    <= 3'd0;
                    r_stopout <= 1'b1;
                end
                O_DATA: begin
                    if (r_bcnt == 3'd7) begin
                        r_state   <= O_IDLE;
                        r_ctl     <= 1'b1;
                        r_data    <= 8'h00;
                        r_stopout <= 1'b0;
                    end else begin
                        r_ctl     <= 1'b0;
                        r_data    <= r_sh[7:0];
                        r_sh      <= {8'h00, r_sh[63:8]};
                        r_bcnt    <= r_bcnt + 3'd1;
                        // Drop stopout for the last byte so the next word can follow directly.
                        r_stopout <= (r_bcnt != 3'd6);
                    end
                end
                default: begin
                    r_state   <= O_IDLE;
                    r_ctl     <= 1'b1;
                    r_data    <= 8'h00;
                    r_stopout <= 1'b0;
                end
            endcase
        end
    end

    assign o_stopout = r_stopout;
    assign o_ctl     = r_ctl;
    assign o_data    = r_data;

endmodule

// File: rtl/perm_noc_ctl.sv
// Permutation NoC controller: assembles NoC bytes into frames of 64-bit
// words for the perm engine and serializes result words back to the NoC.
module perm_noc_ctl
    import perm_noc_pkg::*;
#(
    parameter int         NWORDS  = NWORDS_DEF,
    parameter logic [7:0] HDR_OUT = 8'h02
) (
    input  logic           clk,
    input  logic           reset,
    perm_noc_ctl_if.master bus,
    output logic           busy,
    output logic           ovf_err
);

    localparam logic [4:0] LAST_WORD = 5'(NWORDS - 1);

    in_state_t   r_state;
    logic [55:0] r_asm;
    logic [2:0]  r_byte_cnt;
    logic [4:0]  r_word_cnt;
    logic [63:0] r_din;
    logic        r_pushin;
    logic        r_firstin;
    logic        r_busy;
    logic        r_ovf;

    logic        w_byte_in;
    logic        w_word_done;
    logic        w_accept;
    logic        w_reg_free;
    logic [63:0] w_word;
    logic        w_cmd_start;
    logic        w_cmd_bad;
    logic        w_stopout;
    logic        w_from_ctl;
    logic [7:0]  w_from_data;

    // Byte classification and word-register handshake.
    always_comb begin
        w_byte_in   = (r_state == IN_LOAD) && !bus.noc_to_dev_ctl;
        w_word_done = w_byte_in && (r_byte_cnt == 3'd7);
        w_accept    = r_pushin && !bus.stopin;
        w_reg_free  = !r_pushin || !bus.stopin;
        w_word      = {bus.noc_to_dev_data, r_asm};
        w_cmd_start = bus.noc_to_dev_ctl && (bus.noc_to_dev_data == CMD_START);
        w_cmd_bad   = bus.noc_to_dev_ctl && (bus.noc_to_dev_data != CMD_START)
                                         && (bus.noc_to_dev_data != CMD_NOP);
    end

    // Input FSM, byte assembly, word register and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IN_IDLE;
            r_asm      <= 56'd0;
            r_byte_cnt <= 3'd0;
            r_word_cnt <= 5'd0;
            r_din      <= 64'd0;
            r_pushin   <= 1'b0;
            r_firstin  <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            // A new word may replace one that is leaving in the same cycle.
            if (w_word_done && w_reg_free) begin
                r_din     <= w_word;
                r_pushin  <= 1'b1;
                r_firstin <= (r_word_cnt == 5'd0);
            end else if (w_accept) begin
                r_din     <= 64'd0;
                r_pushin  <= 1'b0;
                r_firstin <= 1'b0;
            end else begin
                r_din     <= r_din;
                r_pushin  <= r_pushin;
                r_firstin <= r_firstin;
            end

            if (w_cmd_bad || (w_cmd_start && (r_state != IN_IDLE)) ||
                (w_word_done && !w_reg_free)) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end

            case (r_state)
                IN_IDLE: begin
                    if (w_cmd_start) begin
                        r_state    <= IN_LOAD;
                        r_byte_cnt <= 3'd0;
                        r_word_cnt <= 5'd0;
                        r_busy     <= 1'b1;
                    end
                end
                IN_LOAD: begin
                    if (w_byte_in) begin
                        r_asm      <= asm_put(r_asm, r_byte_cnt, bus.noc_to_dev_data);
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        // Word counter advances even when the word is dropped.
                        if (r_byte_cnt == 3'd7) begin
                            if (r_word_cnt == LAST_WORD) begin
                                r_word_cnt <= 5'd0;
                                r_state    <= IN_FLUSH;
                            end else begin
                                r_word_cnt <= r_word_cnt + 5'd1;
                            end
                        end
                    end
                end
                IN_FLUSH: begin
                    if (w_reg_free) begin
                        r_state <= IN_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IN_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    perm_noc_ser #(.HDR_OUT(HDR_OUT)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_pushout  (bus.pushout),
        .i_firstout (bus.firstout),
        .i_dout     (bus.dout),
        .o_stopout  (w_stopout),
        .o_ctl      (w_from_ctl),
        .o_data     (w_from_data)
    );

    assign bus.pushin            = r_pushin;
    assign bus.firstin           = r_firstin;
    assign bus.din               = r_din;
    assign bus.stopout           = w_stopout;
    assign bus.noc_from_dev_ctl  = w_from_ctl;
    assign bus.noc_from_dev_data = w_from_data;
    assign busy                  = r_busy;
    assign ovf_err               = r_ovf;

endmodule

// File: tb/tb_perm_noc_ctl.sv
// Directed self-checking bench for perm_noc_ctl.
module tb_perm_noc_ctl;
    import perm_noc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic ovf_err;

    perm_noc_ctl_if u_if ();

    perm_noc_ctl #(.NWORDS(25), .HDR_OUT(8'h02)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (u_if),
        .busy    (busy),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte pattern of a frame: mode 0 is the byte index, mode 1 a scrambled pattern.
    function automatic logic [7:0] bval(input int mode, input int i);
        if (mode == 0) return 8'(i);
        return 8'(i * 3 + 90);
    endfunction

    function automatic logic [63:0] exp_word(input int mode, input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = bval(mode, 8 * k + j);
        return w;
    endfunction

    // Push monitor: records accepted words and din changes during stalls.
    logic [63:0] mon_din [0:31];
    logic        mon_first [0:31];
    int          mon_cnt = 0;
    int          hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_din = 64'd0;
    logic        mon_clr;

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_cnt    = 0;
            hold_err   = 0;
            prev_stall = 1'b0;
        end else begin
            if (u_if.pushin && !u_if.stopin) begin
                if (mon_cnt < 32) begin
                    mon_din[mon_cnt]   = u_if.din;
                    mon_first[mon_cnt] = u_if.firstin;
                end
                mon_cnt++;
            end
            if (prev_stall && (u_if.din !== prev_din)) hold_err++;
            prev_stall = u_if.pushin && u_if.stopin;
            prev_din   = u_if.din;
        end
    end

    task automatic set_idle();
        u_if.noc_to_dev_ctl  = 1'b1;
        u_if.noc_to_dev_data = 8'h00;
        u_if.stopin          = 1'b0;
        u_if.pushout         = 1'b0;
        u_if.firstout        = 1'b0;
        u_if.dout            = 64'd0;
    endtask

    task automatic put_byte(input logic ctl, input logic [7:0] data, input logic stop);
        u_if.noc_to_dev_ctl  = ctl;
        u_if.noc_to_dev_data = data;
        u_if.stopin          = stop;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int nbytes, input int stall_at,
                              input int nstall, input int inject_at);
        put_byte(1'b1, CMD_START, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            if (i == inject_at) begin
                put_byte(1'b1, 8'h05, 1'b0);
                put_byte(1'b1, CMD_START, 1'b0);
            end
            put_byte(1'b0, bval(mode, i), (i >= stall_at) && (i < stall_at + nstall));
        end
        set_idle();
    endtask

    function automatic int bad_words(input int mode);
        int bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (mon_din[k] !== exp_word(mode, k) || mon_first[k] !== (k == 0)) bad++;
        end
        return bad;
    endfunction

    logic [63:0] w1;
    logic [63:0] w2;
    logic [8:0]  exp_b;
    int          sent;

    initial begin
        set_idle();
        reset   = 1'b1;
        mon_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        mon_clr = 1'b0;

        check_val("rst_pushin",  u_if.pushin, 1'b0);
        check_val("rst_firstin", u_if.firstin, 1'b0);
        check_val("rst_din",     u_if.din, 64'd0);
        check_val("rst_stopout", u_if.stopout, 1'b0);
        check_val("rst_ctl",     u_if.noc_from_dev_ctl, 1'b1);
        check_val("rst_data",    u_if.noc_from_dev_data, 8'h00);
        check_val("rst_busy",    busy, 1'b0);
        check_val("rst_ovf",     ovf_err, 1'b0);

        // Basic frame, no backpressure.
        clear_mon();
        send_frame(0, 200, 1000, 0, -1);
        check_val("t1_last_push", u_if.pushin, 1'b1);
        check_val("t1_last_din",  u_if.din, 64'hC7C6C5C4C3C2C1C0);
        check_val("t1_busy_hi",   busy, 1'b1);
        @(posedge clk); #1;
        check_val("t1_busy_lo",   busy, 1'b0);
        check_val("t1_push_lo",   u_if.pushin, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("t1_count",  mon_cnt, 25);
        check_val("t1_first0", mon_first[0], 1'b1);
        check_val("t1_din0",   mon_din[0], 64'h0706050403020100);
        check_val("t1_din24",  mon_din[24], 64'hC7C6C5C4C3C2C1C0);
        check_val("t1_words",  bad_words(0), 0);
        check_val("t1_ovf",    ovf_err, 1'b0);

        // Short stall on word 5: no loss.
        do_reset();
        clear_mon();
        send_frame(0, 200, 48, 3, -1);
        repeat (3) @(posedge clk);
        #1;
        check_val("t2_count", mon_cnt, 25);
        check_val("t2_words", bad_words(0), 0);
        check_val("t2_hold",  hold_err, 0);
        check_val("t2_ovf",   ovf_err, 1'b0);

        // Long stall on word 5: word 6 is dropped.
        do_reset();
        clear_mon();
        send_frame(0, 200, 48, 10, -1);
        repeat (3) @(posedge clk);
        #1;
        check_val("t3_ovf",   ovf_err, 1'b1);
        check_val("t3_count", mon_cnt, 24);
        check_val("t3_din5",  mon_din[5], exp_word(0, 5));
        check_val("t3_din6",  mon_din[6], exp_word(0, 7));
        check_val("t3_hold",  hold_err, 0);

        // Reset in the middle of a frame, then a fresh frame.
        do_reset();
        clear_mon();
        send_frame(0, 100, 1000, 0, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("t4_busy",   busy, 1'b0);
        check_val("t4_pushin", u_if.pushin, 1'b0);
        clear_mon();
        send_frame(1, 200, 1000, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        check_val("t4_count",  mon_cnt, 25);
        check_val("t4_first0", mon_first[0], 1'b1);
        check_val("t4_din0",   mon_din[0], exp_word(1, 0));
        check_val("t4_words",  bad_words(1), 0);

        // Bad command and START while loading.
        do_reset();
        clear_mon();
        send_frame(0, 200, 1000, 0, 50);
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_ovf",   ovf_err, 1'b1);
        check_val("t5_count", mon_cnt, 25);
        check_val("t5_words", bad_words(0), 0);

        // Result return: header word then a plain word back to back.
        do_reset();
        w1   = 64'h1122334455667788;
        w2   = 64'hA1B2C3D4E5F60718;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            if (sent < 2 && !u_if.stopout) begin
                u_if.pushout  = 1'b1;
                u_if.firstout = (sent == 0);
                u_if.dout     = (sent == 0) ? w1 : w2;
                sent++;
            end else begin
                u_if.pushout  = 1'b0;
                u_if.firstout = 1'b0;
                u_if.dout     = 64'd0;
            end
            if (c == 1)                  exp_b = {1'b1, 8'h02};
            else if (c >= 2 && c <= 9)   exp_b = {1'b0, w1[(c-2)*8 +: 8]};
            else if (c >= 10 && c <= 17) exp_b = {1'b0, w2[(c-10)*8 +: 8]};
            else                         exp_b = {1'b1, 8'h00};
            @(negedge clk);
            check_val($sformatf("t6_byte%0d", c),
                      {u_if.noc_from_dev_ctl, u_if.noc_from_dev_data}, exp_b);
            if (c == 5) check_val("t6_stop_mid",  u_if.stopout, 1'b1);
            if (c == 9) check_val("t6_stop_last", u_if.stopout, 1'b0);
            @(posedge clk); #1;
        end
        check_val("t6_sent", sent, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
